lbp_result_sink: RTL

Receiving end of the LBP engine's result-write interface (`lbp_valid`/`lbp_addr`/`lbp_data`/`finish`). It clears a 2^ADDR_W-entry result RAM, captures every LBP write, and on `finish` drains the whole image in address order over a valid/ready stream. It sits between the LBP engine and the downstream output/DMA path, replacing the behavioural result memory with synthesizable RTL.

---
 rtl/lbp_result_sink.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/lbp_result_sink.sv
// Result RAM behind the LBP engine: zero-fills the image, captures engine writes,
// then drains every address in order over a valid/ready stream.
module lbp_result_sink #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    output logic              sink_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [ADDR_W:0]   wr_count,
    output logic              drop_err,
    output logic              done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_CLEAR   = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_q;

    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_all;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic              skid_valid;
    logic [ADDR_W-1:0] skid_addr;
    logic [DATA_W-1:0] skid_data;
    logic              skid_last;

    logic              xfer;
    logic              rd_issue;
    logic [1:0]        occ_after;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Handshake: a beat moves on a rising edge where out_valid && out_ready; while
    // out_valid is high without out_ready, addr/data/last are frozen and valid stays up.
    assign xfer = out_valid && out_ready;

    // A read issued now lands one cycle later and must find a free buffer slot even if
    // the downstream stalls, so only issue when at most one entry remains occupied.
    assign occ_after = 2'(out_valid) + 2'(skid_valid) + 2'(pend_valid) - 2'(xfer);
    assign rd_issue  = (state == S_DRAIN) && !rd_all && (occ_after <= 2'd1);

    assign sink_ready = (state == S_CAPTURE);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_waddr  = lbp_addr;
        mem_wdata  = lbp_data;
        case (state)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = '0;
                if (clr_cnt == LAST_ADDR) state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                mem_we = lbp_valid;
                if (finish) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (xfer && out_last) state_next = S_DONE;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (rd_issue) rd_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt    <= '0;
            rd_ptr     <= '0;
            rd_all     <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            out_last   <= 1'b0;
            wr_count   <= '0;
            drop_err   <= 1'b0;
        end else begin
            if (state == S_CLEAR && clr_cnt != LAST_ADDR) clr_cnt <= clr_cnt + 1'b1;

            if (state == S_CAPTURE && lbp_valid && wr_count != '1) wr_count <= wr_count + 1'b1;
            if (lbp_valid && state != S_CAPTURE) drop_err <= 1'b1;

            pend_valid <= rd_issue;
            if (rd_issue) begin
                pend_addr <= rd_ptr;
                if (rd_ptr == LAST_ADDR) rd_all <= 1'b1;
                else rd_ptr <= rd_ptr + 1'b1;
            end

            // Skid entry is always older than the RAM beat, so it refills the output first.
            if (!out_valid || xfer) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_addr   <= skid_addr;
                    out_data   <= skid_data;
                    out_last   <= skid_last;
                    skid_valid <= pend_valid;
                    if (pend_valid) begin
                        skid_addr <= pend_addr;
                        skid_data <= rd_q;
                        skid_last <= (pend_addr == LAST_ADDR);
                    end
                end else begin
                    out_valid <= pend_valid;
                    if (pend_valid) begin
                        out_addr <= pend_addr;
                        out_data <= rd_q;
                        out_last <= (pend_addr == LAST_ADDR);
                    end
                end
            end else if (pend_valid) begin
                skid_valid <= 1'b1;
                skid_addr  <= pend_addr;
                skid_data  <= rd_q;
                skid_last  <= (pend_addr == LAST_ADDR);
            end
        end
    end

endmodule
